// File: rtl/key_loader_pkg.sv
// ============================================================================
// Module      : key_loader_pkg
// Description : Shared width, state encoding and reset value for key_loader.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package key_loader_pkg;

    localparam int KEY_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_READY  = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    localparam logic [KEY_W_DEFAULT-1:0] c_KEY_RESET = '0;

endpackage

`default_nettype wire

// File: rtl/key_loader_if.sv
// ============================================================================
// Module      : key_loader_if
// Description : Programming port and published-key bundle of key_loader.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface key_loader_if #(
    parameter int KEY_W = key_loader_pkg::KEY_W_DEFAULT
);
    logic             prog_en;
    logic             prog_valid;
    logic             prog_bit;
    logic             lock_req;
    logic [KEY_W-1:0] key;
    logic             key_valid;
    logic             locked;
    logic             err;

    // The provisioning agent drives the programming port.
    modport master (
        output prog_en, prog_valid, prog_bit, lock_req,
        input  key, key_valid, locked, err
    );

    // The key loader consumes programming traffic and publishes the key.
    modport slave (
        input  prog_en, prog_valid, prog_bit, lock_req,
        output key, key_valid, locked, err
    );
endinterface

`default_nettype wire

// File: rtl/key_loader_key_shift_reg.sv
// ============================================================================
// Module      : key_shift_reg
// Description : Serial MSB-first shadow register and bit counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module key_shift_reg
    import key_loader_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEFAULT
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clear,
    input  wire logic             shift_en,
    input  wire logic             data_bit,
    output logic      [KEY_W-1:0] next_shadow,
    output logic                  done
);
    localparam int CNT_W = $clog2(KEY_W + 1);

    logic [KEY_W-1:0] r_shadow;
    logic [CNT_W-1:0] r_count;

    // Shadow value including the bit being accepted this cycle.
    assign next_shadow = {r_shadow[KEY_W-2:0], data_bit};
    assign done        = shift_en && (r_count == CNT_W'(KEY_W - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_shadow <= '0;
            r_count  <= '0;
        end else if (shift_en) begin
            r_shadow <= next_shadow;
            r_count  <= done ? '0 : r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/key_loader.sv
// ============================================================================
// Module      : key_loader
// Description : Serial key provisioning FSM with sticky lock and fault strobe.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module key_loader
    import key_loader_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEFAULT
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    key_loader_if.slave bus
);
    state_t           r_state;
    logic [KEY_W-1:0] r_key;
    logic             r_key_valid;
    logic             r_locked;
    logic             r_err;

    logic             w_clear;
    logic             w_shift_en;
    logic             w_done;
    logic [KEY_W-1:0] w_next_shadow;

    always_comb begin
        w_clear    = 1'b0;
        w_shift_en = 1'b0;
        case (r_state)
            ST_IDLE:  w_clear = bus.prog_en;
            ST_READY: w_clear = bus.prog_en && !bus.lock_req;
            ST_SHIFT: w_shift_en = bus.prog_en && bus.prog_valid;
            default:  ;
        endcase
    end

    key_shift_reg #(
        .KEY_W (KEY_W)
    ) u_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (w_clear),
        .shift_en    (w_shift_en),
        .data_bit    (bus.prog_bit),
        .next_shadow (w_next_shadow),
        .done        (w_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_key       <= KEY_W'(c_KEY_RESET);
            r_key_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.lock_req) r_err <= 1'b1;
                    if (bus.prog_en) begin
                        r_state     <= ST_SHIFT;
                        r_key       <= KEY_W'(c_KEY_RESET);
                        r_key_valid <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    // Dropping prog_en aborts before any bit of that cycle is taken.
                    if (!bus.prog_en) begin
                        r_state <= ST_IDLE;
                        r_err   <= 1'b1;
                    end else begin
                        if (bus.lock_req) r_err <= 1'b1;
                        if (w_done) begin
                            r_state     <= ST_READY;
                            r_key       <= w_next_shadow;
                            r_key_valid <= 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    if (bus.lock_req) begin
                        r_state  <= ST_LOCKED;
                        r_locked <= 1'b1;
                    end else if (bus.prog_en) begin
                        r_state     <= ST_SHIFT;
                        r_key       <= KEY_W'(c_KEY_RESET);
                        r_key_valid <= 1'b0;
                    end
                end
                ST_LOCKED: r_err <= bus.prog_en;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.key       = r_key;
    assign bus.key_valid = r_key_valid;
    assign bus.locked    = r_locked;
    assign bus.err       = r_err;

endmodule

`default_nettype wire
